// File: rtl/spi_mem_oversampled.sv
// spi_mem_oversampled: clk-domain SPI mode-0 memory slave driving an 8-bit bus; `SPI_MEM_ADDR_AUTOINC_EN enables per-byte address increment
module spi_mem_oversampled #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  _select,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rd,
  output logic                  wr,
  output logic                  busy
);
`ifdef SPI_MEM_ADDR_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_t;
  state_t state, state_n;
  logic [1:0] sel_s, mosi_s;
  logic [2:0] sck_s, cnt;
  logic [DATA_WIDTH-2:0] sr;
  logic [DATA_WIDTH-1:0] pf, tx, rx_byte;
  logic [6:0] a_hi;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic w, load, adv, rd_req, sel, rise, fall, bit_rise, byte_done, addr_done, rd_first, prefetch, wr_hit;
  assign sel       = sel_s[1];
  assign rise      = sck_s[1] & ~sck_s[2];
  assign fall      = ~sck_s[1] & sck_s[2];
  // deselect masks any coincident sck rise
  assign bit_rise  = rise && !sel && state != IDLE;
  assign byte_done = bit_rise && cnt == 3'(DATA_WIDTH - 1);
  assign rx_byte   = {sr, mosi_s[1]};
  assign addr_done = byte_done && state == ADDR;
  assign rd_first  = addr_done && !w;
  assign prefetch  = bit_rise && cnt == 3'd0 && state == DATA && !w;
  assign wr_hit    = byte_done && state == DATA && w;
  assign addr_inc  = AUTOINC ? addr + ADDR_WIDTH'(1) : addr;
  assign miso      = tx[DATA_WIDTH-1];
  assign miso_oe   = state != IDLE;
  always_comb begin
    state_n = state;
    if (sel) state_n = IDLE;
    else if (state == IDLE) state_n = CMD;
    else if (byte_done) state_n = state == CMD ? ADDR : state == ADDR ? (w ? DATA : DUMMY) : DATA;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel_s    <= 2'b11;
      sck_s    <= '0;
      mosi_s   <= '0;
      cnt      <= '0;
      sr       <= '0;
      pf       <= '0;
      tx       <= '0;
      a_hi     <= '0;
      rd_pipe  <= '0;
      w        <= 1'b0;
      load     <= 1'b0;
      adv      <= 1'b0;
      rd_req   <= 1'b0;
      addr     <= '0;
      data_out <= '0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      sel_s    <= {sel_s[0], _select};
      sck_s    <= {sck_s[1:0], sck};
      mosi_s   <= {mosi_s[0], mosi};
      cnt      <= (sel || state == IDLE) ? '0 : bit_rise ? cnt + 3'd1 : cnt;
      busy     <= !sel && (busy || bit_rise);
      rd       <= rd_first || rd_req;
      rd_req   <= prefetch;
      wr       <= wr_hit;
      adv      <= wr_hit;
      rd_pipe  <= READ_LATENCY'({rd_pipe, rd});
      // a read byte boundary arms the next sck fall to load the prefetched byte
      load     <= !sel && ((byte_done && !w && (state == DUMMY || state == DATA)) || (load && !fall));
      addr     <= addr_done ? ADDR_WIDTH'({a_hi, rx_byte}) : (adv || prefetch) ? addr_inc : addr;
      tx       <= state == IDLE ? '0 : !fall ? tx : load ? pf : {tx[DATA_WIDTH-2:0], 1'b0};
      if (bit_rise) sr <= rx_byte[DATA_WIDTH-2:0];
      if (byte_done && state == CMD) {w, a_hi} <= rx_byte;
      if (rd_pipe[READ_LATENCY-1]) pf <= data_in;
      if (wr_hit) data_out <= rx_byte;
    end
  end
endmodule

// File: doc/spi_mem_oversampled.md
Name: spi_mem_oversampled

Overview:
SPI memory slave that runs entirely in the core `clk` domain. It samples `_select`, `sck` and `mosi` through synchronizers. It decodes a command/address/data byte stream and issues single-cycle read/write strobes on an 8-bit internal memory bus. It sits between the SPI bus multiplexer and the 8-to-16-bit bus converter in front of `Core`, and replaces the `sck`-clocked slave, so every MPU strobe is already synchronous to `clk`.

Parameters:
- ADDR_WIDTH, 15, byte-address width on the internal bus.
- DATA_WIDTH, 8, bus data width; fixed at 8, one SPI byte per transfer.
- READ_LATENCY, 2, `clk` cycles from the `rd` strobe to valid `data_in`; legal range 1..4.

Ports:
- clk  in  1  core clock; must be ≥ 8× the SPI `sck` frequency.
- reset  in  1  synchronous, active-high reset.
- _select  in  1  SPI chip select, active low, asynchronous to `clk`.
- sck  in  1  SPI clock, mode 0, asynchronous.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out.
- miso_oe  out  1  1 while selected; the top level tristates `miso` when this is 0.
- addr  out  ADDR_WIDTH  bus address.
- data_out  out  8  write data to the bus.
- data_in  in  8  read data from the bus.
- rd  out  1  one-cycle read strobe.
- wr  out  1  one-cycle write strobe.
- busy  out  1  1 from the first command bit until `_select` deasserts.

Behaviour:
- Clock and reset: one clock (`clk`). Reset is synchronous and active-high.
- Reset values: `rd`=0, `wr`=0, `addr`=0, `data_out`=0, `miso`=0, `miso_oe`=0, `busy`=0; state=IDLE; bit counter=0.
- Synchronizers: 2-FF synchronizer on each of `_select`, `sck`, `mosi`. Edge detect on synchronized `sck` gives `rise` and `fall` pulses, each one cycle wide.
- Sampling: `mosi` is shifted in MSB-first on `rise`. `miso` updates on `fall`. A bit counter (0..7) increments on each `rise` while selected.
- Byte format:
  - byte0 = {W, addr[14:8]}, where W=1 is write and W=0 is read.
  - byte1 = addr[7:0].
  - Read transfers insert one dummy byte after byte1.
  - All following bytes are data.
- States (each advances on the 8th `rise` of its byte):
  - IDLE → CMD when synchronized `_select` falls.
  - CMD → ADDR; latches W and addr[14:8].
  - ADDR → DATA (write) or DUMMY (read); latches addr[7:0]. On a read it pulses `rd` with the full address on the same cycle.
  - DUMMY → DATA.
  - DATA → DATA.
  - Any state → IDLE when synchronized `_select` rises.
- Read path:
  - `data_in` is captured into the prefetch register exactly READ_LATENCY cycles after `rd`.
  - On the `fall` following the 8th `rise` of the DUMMY byte or of any DATA byte: the prefetch register loads into the tx shift register, and `miso` = tx[7].
  - On each later `fall`, tx shifts left by 1.
  - On the 1st `rise` of each read DATA byte, `addr` advances, then `rd` pulses one cycle later (prefetch of the next byte).
- Write path:
  - On the 8th `rise` of a DATA byte: `data_out` = received byte, and `wr` pulses in the same cycle with the current `addr`.
  - The following cycle, `addr` advances.
- Address advance: `addr`+1 modulo 2^ADDR_WIDTH, so 0x7FFF wraps to 0x0000.
- `rd` and `wr` are never both 1 in the same cycle. Each strobe is exactly 1 cycle.
- `miso` before the first data byte (during CMD/ADDR/DUMMY) = 0.
- `_select` deasserted mid-byte:
  - the partial byte is discarded, with no `wr`;
  - state → IDLE; `busy`=0 on the next cycle;
  - `addr` holds its last value.
- `_select` reasserted without a full-byte gap: a fresh transaction starts at CMD.
- Reset mid-transaction: the transaction aborts immediately, all outputs take reset values, and no strobe is issued in the reset cycle.
- A `rise` and a `_select` rise in the same cycle: deselect wins and the bit is ignored.

Optional Feature:
- Macro: SPI_MEM_ADDR_AUTOINC_EN.
- Defined: the address advances per data byte, as described above.
- Undefined:
  - `addr` is fixed after ADDR (port-style access).
  - Repeated writes hit the same address.
  - Read prefetches re-read the same address every byte.
  - Strobe timing is unchanged.

Test Plan:
- Write burst: reset, select, send 0x81 0x23 0xAA 0x55 → `wr` pulses twice: (addr 0x0123, data 0xAA), then (0x0124, 0x55). No `rd` pulses.
- Read burst: bus model returns low byte of address; send 0x00 0x10 dummy, then 2 clocks of data → `rd` at 0x0010, then 0x0011; MISO bytes = 0x10, 0x11.
- Wrap: write to 0x7FFF with 2 data bytes → second `wr` at 0x0000.
- Abort: deselect after 5 bits of a write data byte → no `wr`, `busy`=0, next transaction decodes correctly.
- Reset mid-read during DUMMY → all outputs 0 next cycle. A following write of 0x80 0x00 0x5A gives `wr` at 0x0000 with 0x5A.
- Macro undefined: write burst 0x81 0x00 0x01 0x02 0x03 → three `wr` pulses all at 0x0100.
